alu_seq: RTL and testbench

//  Parametrised, registered ALU with valid/ready handshakes on input and output.

---
 rtl/alu_if.sv | 40 ++++
 rtl/alu_seq.sv | 194 +++++++++++++++++++
 tb/tb_alu_seq.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/alu_if.sv
// ---------------------------------------------------------------------------
// alu_if -- handshake/data bundle between an operation source and alu_seq.
//
// Macro: none (the optional multiply is selected inside alu_seq by ALU_MUL_EN).
//
// Signals (directions seen from the ALU, i.e. the slave modport):
//   in_valid   in   1      operands/op valid
//   in_ready   out  1      ALU can accept a new operation
//   a, b       in   WIDTH  operands
//   op         in   4      opcode
//   src_sel    in   2      unary-op operand select (1 -> B, else A)
//   out_valid  out  1      result/flags valid
//   out_ready  in   1      downstream accepts result
//   result     out  WIDTH  registered result
//   flags      out  4      {N,V,C,Z}
// ---------------------------------------------------------------------------
interface alu_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic [1:0]       src_sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;

  modport master (
    output in_valid, a, b, op, src_sel, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, a, b, op, src_sel, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq -- registered ALU with valid/ready handshakes on both sides.
//
// Single-cycle ops are evaluated from the bus inputs at the accept edge and
// land directly in the output registers. With ALU_MUL_EN defined, op 4'b1010
// runs an unsigned shift-add multiply, one multiplier bit per clock, and the
// low WIDTH bits of the 2*WIDTH-bit product become the result. Without the
// macro, op 4'b1010 falls through to the default A+B and no multiplier
// hardware is built.
//
// Configuration macro: ALU_MUL_EN
//
// Ports:
//   clk    in  1   rising-edge clock
//   rst_n  in  1   asynchronous, active-low reset
//   bus    alu_if.slave  handshakes, operands, result and flags {N,V,C,Z}
// ---------------------------------------------------------------------------
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic  clk,
  input  logic  rst_n,
  alu_if.slave  bus
);

`ifdef ALU_MUL_EN
  localparam int CNT_W = $clog2(WIDTH) + 1;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
`ifdef ALU_MUL_EN
    S_BUSY,
`endif
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic             rdy_en_q;        // low until the first clock after reset release
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;

  logic             accept;
  logic [WIDTH-1:0] src_c;
  logic [WIDTH:0]   sum_c, diff_c;
  logic [WIDTH-1:0] res_c;
  logic             c_c, v_c;

`ifdef ALU_MUL_EN
  logic             is_mul;
  logic [2*WIDTH-1:0] prod_q, prod_d, prod_step;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  assign is_mul    = (bus.op == 4'b1010);
  // Partial product for the current multiplier bit, including this step.
  assign prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);
`endif

  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.in_ready  = rdy_en_q && (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;

  // -------------------------------------------------------------------------
  // Single-cycle operation datapath
  // -------------------------------------------------------------------------
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the case statement leaves it unassigned and infers a latch.
  always_comb begin
    src_c  = (bus.src_sel == 2'd1) ? bus.b : bus.a;
    sum_c  = {1'b0, bus.a} + {1'b0, bus.b};
    diff_c = {1'b0, bus.a} - {1'b0, bus.b};
    res_c  = sum_c[WIDTH-1:0];
    c_c    = sum_c[WIDTH];
    v_c    = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
             (sum_c[WIDTH-1] != bus.a[WIDTH-1]);
    unique case (bus.op)
      4'b0000: begin res_c = bus.a & bus.b; c_c = 1'b0; v_c = 1'b0; end
      4'b0001: begin res_c = bus.a | bus.b; c_c = 1'b0; v_c = 1'b0; end
      4'b0011: begin res_c = src_c >> 1;    c_c = src_c[0];       v_c = 1'b0; end
      4'b0100: begin res_c = src_c << 1;    c_c = src_c[WIDTH-1]; v_c = 1'b0; end
      4'b0101: begin res_c = ~src_c;        c_c = 1'b0; v_c = 1'b0; end
      4'b0110: begin
        // Borrow out of the extended subtraction is exactly A < B unsigned.
        res_c = diff_c[WIDTH-1:0];
        c_c   = diff_c[WIDTH];
        v_c   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                (diff_c[WIDTH-1] != bus.a[WIDTH-1]);
      end
      4'b0111: begin res_c = bus.a ^ bus.b; c_c = 1'b0; v_c = 1'b0; end
      4'b1000: begin
        res_c = {bus.a[WIDTH-2:0], bus.a[WIDTH-1]};
        c_c   = bus.a[WIDTH-1];
        v_c   = 1'b0;
      end
      4'b1001: begin
        res_c = {bus.a[0], bus.a[WIDTH-1:1]};
        c_c   = bus.a[0];
        v_c   = 1'b0;
      end
      default: ;  // A+B, including 4'b1010 when the multiplier is absent
    endcase
  end

  // -------------------------------------------------------------------------
  // Next-state and register-load logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
`ifdef ALU_MUL_EN
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
`ifdef ALU_MUL_EN
          if (is_mul) begin
            state_d  = S_BUSY;
            prod_d   = '0;
            mcand_d  = {{WIDTH{1'b0}}, bus.a};
            mplier_d = bus.b;
            cnt_d    = '0;
          end else
`endif
          begin
            state_d  = S_DONE;
            result_d = res_c;
            flags_d  = {res_c[WIDTH-1], v_c, c_c, (res_c == '0)};
          end
        end
      end
`ifdef ALU_MUL_EN
      S_BUSY: begin
        prod_d   = prod_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d  = S_DONE;
          result_d = prod_step[WIDTH-1:0];
          // C reports any product bits lost above WIDTH; V is always clear.
          flags_d  = {prod_step[WIDTH-1], 1'b0, |prod_step[2*WIDTH-1:WIDTH],
                      (prod_step[WIDTH-1:0] == '0)};
        end
      end
`endif
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before the edge, independent of process order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rdy_en_q <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      rdy_en_q <= 1'b1;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

`ifdef ALU_MUL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq -- directed, table-driven bench for alu_seq at WIDTH=8.
// Expected values for op 4'b1010 follow ALU_MUL_EN as defined for this build.
// ---------------------------------------------------------------------------
module tb_alu_seq;

  localparam int W = 8;
`ifdef ALU_MUL_EN
  localparam int MUL_LAT = W + 1;
  localparam logic [7:0] MUL_RES = 8'h00;
  localparam logic [3:0] MUL_FLG = 4'b0011;
`else
  localparam int MUL_LAT = 1;
  localparam logic [7:0] MUL_RES = 8'h30;
  localparam logic [3:0] MUL_FLG = 4'b0000;
`endif

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
    logic [1:0] src_sel;
    logic [7:0] res;
    logic [3:0] flg;   // {N,V,C,Z}
    int         lat;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one op, scramble the inputs after accept, and measure latency.
  // Leaves the result pending when do_release is 0.
  task automatic run_op(input vec_t v, input string tag, input bit do_release);
    int lat;
    check({tag, " in_ready before"}, 32'(bus.in_ready), 32'd1);
    bus.a        = v.a;
    bus.b        = v.b;
    bus.op       = v.op;
    bus.src_sel  = v.src_sel;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a        = ~v.a;
    bus.b        = ~v.b;
    bus.op       = 4'b0111;
    bus.src_sel  = ~v.src_sel;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " out_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, " latency"},   32'(lat),           32'(v.lat));
    check({tag, " result"},    32'(bus.result),    32'(v.res));
    check({tag, " flags"},     32'(bus.flags),     32'(v.flg));
    if (do_release) begin
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check({tag, " out_valid cleared"}, 32'(bus.out_valid), 32'd0);
    end
  endtask

  vec_t vecs[16];
  vec_t v;
  int   seen;

  initial begin
    checks = 0;
    errors = 0;
    //           a      b      op       sel    res    {N,V,C,Z}  lat
    vecs[0]  = '{8'hFF, 8'h01, 4'b0010, 2'd0, 8'h00, 4'b0011, 1};       // add carry, zero
    vecs[1]  = '{8'h80, 8'h01, 4'b0110, 2'd0, 8'h7F, 4'b0100, 1};       // sub overflow
    vecs[2]  = '{8'h01, 8'h02, 4'b0110, 2'd0, 8'hFF, 4'b1010, 1};       // sub borrow
    vecs[3]  = '{8'h00, 8'h03, 4'b0011, 2'd1, 8'h01, 4'b0010, 1};       // shr from B
    vecs[4]  = '{8'h00, 8'h03, 4'b0011, 2'd2, 8'h00, 4'b0001, 1};       // shr from A
    vecs[5]  = '{8'hF0, 8'h3C, 4'b0000, 2'd0, 8'h30, 4'b0000, 1};       // and
    vecs[6]  = '{8'h80, 8'h01, 4'b0001, 2'd0, 8'h81, 4'b1000, 1};       // or
    vecs[7]  = '{8'hAA, 8'hAA, 4'b0111, 2'd0, 8'h00, 4'b0001, 1};       // xor
    vecs[8]  = '{8'h0F, 8'h00, 4'b0101, 2'd0, 8'hF0, 4'b1000, 1};       // not A
    vecs[9]  = '{8'h0F, 8'h00, 4'b0101, 2'd1, 8'hFF, 4'b1000, 1};       // not B
    vecs[10] = '{8'h81, 8'h00, 4'b0100, 2'd3, 8'h02, 4'b0010, 1};       // shl from A
    vecs[11] = '{8'h81, 8'h00, 4'b1000, 2'd0, 8'h03, 4'b0010, 1};       // rotl
    vecs[12] = '{8'h81, 8'h00, 4'b1001, 2'd0, 8'hC0, 4'b1010, 1};       // rotr
    vecs[13] = '{8'h7F, 8'h01, 4'b0010, 2'd0, 8'h80, 4'b1100, 1};       // add overflow
    vecs[14] = '{8'h05, 8'h03, 4'b1111, 2'd0, 8'h08, 4'b0000, 1};       // default add
    vecs[15] = '{8'h10, 8'h20, 4'b1010, 2'd0, MUL_RES, MUL_FLG, MUL_LAT}; // mul

    // Reset values while held in reset, and in_ready timing after release.
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.op        = '0;
    bus.src_sel   = '0;
    #1;
    check("reset in_ready",  32'(bus.in_ready),  32'd0);
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset result",    32'(bus.result),    32'd0);
    check("reset flags",     32'(bus.flags),     32'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    #1 check("in_ready before first clk", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    check("in_ready after first clk", 32'(bus.in_ready), 32'd1);

    foreach (vecs[i]) run_op(vecs[i], $sformatf("vec%0d", i), 1'b1);

    // Back-pressure: result held, new requests refused for 5 cycles.
    v = '{8'h03, 8'h04, 4'b0010, 2'd0, 8'h07, 4'b0000, 1};
    run_op(v, "bp", 1'b0);
    for (int i = 0; i < 5; i++) begin
      bus.a        = 8'h55 + 8'(i);
      bus.b        = 8'h11;
      bus.op       = 4'b0001;
      bus.in_valid = (i % 2) == 0;
      @(posedge clk); #1;
      check($sformatf("bp%0d in_ready", i),  32'(bus.in_ready),  32'd0);
      check($sformatf("bp%0d out_valid", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("bp%0d result", i),    32'(bus.result),    32'h07);
      check($sformatf("bp%0d flags", i),     32'(bus.flags),     32'h0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("bp release out_valid", 32'(bus.out_valid), 32'd0);
    check("bp release in_ready",  32'(bus.in_ready),  32'd1);
    seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    check("bp no stray op", 32'(seen), 32'd0);

    // Reset in the middle of an operation (BUSY for the multiply build,
    // DONE with a pending result otherwise): outputs clear at once.
    bus.a        = 8'h03;
    bus.b        = 8'h05;
    bus.op       = 4'b1010;
    bus.src_sel  = 2'd0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst result",    32'(bus.result),    32'd0);
    check("midrst flags",     32'(bus.flags),     32'd0);
    check("midrst in_ready",  32'(bus.in_ready),  32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst in_ready after clk", 32'(bus.in_ready), 32'd1);
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    check("midrst aborted op silent", 32'(seen), 32'd0);

    // Pipeline still works after the abort.
    run_op(vecs[15], "post-reset mul", 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
